between_to_fifo: RTL

Receiving end of the 8-bit parallel inter-board link driven by `Out_to_between`. It captures each byte presented on `t0`–`t7` under the `tsent`/`trecieve` four-phase handshake, writes the byte into the local `FIFO`, and keeps a running CRC-8 of accepted bytes for the seven-segment display. `isFinish` signals the end of a burst.

---
 rtl/between_to_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/between_to_fifo.sv
// Receiving end of the 8-bit parallel inter-board link: four-phase tsent/trecieve handshake into a FIFO.
// Optional running CRC-8 (poly 0x07) of written bytes is compiled in with BETWEEN_CRC8_EN.
module between_to_fifo #(
    parameter int IDLE_TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       t0,
    input  logic       t1,
    input  logic       t2,
    input  logic       t3,
    input  logic       t4,
    input  logic       t5,
    input  logic       t6,
    input  logic       t7,
    input  logic       tsent,
    output logic       trecieve,
    input  logic       fifo_busy,
    input  logic       fifo_full,
    output logic [7:0] fifo_data_out,
    output logic       fifo_we,
    output logic [7:0] data,
    output logic [7:0] CRC,
    output logic [3:0] error,
    output logic       isFinish
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WRITE, S_ACK} state_t;

    localparam logic [15:0] LP_TIMEOUT = 16'(IDLE_TIMEOUT);

    state_t      r_state, w_next;
    logic        r_sync1, r_ts;
    logic [7:0]  r_data;
    logic [2:0]  r_err;
    logic [7:0]  r_stall;
    logic [15:0] r_idle;
    logic        r_armed, r_fin;
    logic        w_we, w_drop, w_abort, w_stall, w_fin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_ts    <= 1'b0;
            r_state <= S_IDLE;
        end else begin
            r_sync1 <= tsent;
            r_ts    <= r_sync1;
            r_state <= w_next;
        end
    end

    // Abort outranks full, full outranks busy.
    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_drop  = 1'b0;
        w_abort = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:    if (r_ts && enable) w_next = S_CAPTURE;
            S_CAPTURE: begin
                if (!r_ts) begin
                    w_next  = S_IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!r_ts) begin
                    w_next  = S_IDLE;
                    w_abort = 1'b1;
                end else if (fifo_full) begin
                    w_next = S_ACK;
                    w_drop = 1'b1;
                end else if (fifo_busy) begin
                    w_stall = 1'b1;
                end else begin
                    w_next = S_ACK;
                    w_we   = 1'b1;
                end
            end
            S_ACK:     if (!r_ts) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_fin = r_armed && (r_idle == LP_TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_err   <= 3'b000;
            r_stall <= 8'h00;
            r_idle  <= 16'h0000;
            r_armed <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            if (r_state == S_CAPTURE) begin
                r_data  <= {t7, t6, t5, t4, t3, t2, t1, t0};
                r_stall <= 8'h00;
            end
            if (w_drop)  r_err[0] <= 1'b1;
            if (w_abort) r_err[1] <= 1'b1;
            // The 256th consecutive busy cycle flags the stall; the handshake keeps waiting.
            if (w_stall) begin
                if (r_stall == 8'hFF) r_err[2] <= 1'b1;
                else                  r_stall  <= r_stall + 8'h01;
            end
            if (w_we || w_drop)
                r_idle <= 16'h0000;
            else if (r_state == S_IDLE && r_idle != 16'hFFFF)
                r_idle <= r_idle + 16'h0001;
            if (w_we || w_drop) r_armed <= 1'b1;
            else if (w_fin)     r_armed <= 1'b0;
            r_fin <= w_fin;
        end
    end

`ifdef BETWEEN_CRC8_EN
    logic [7:0] r_crc;

    function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     r_crc <= 8'h00;
        else if (w_we) r_crc <= f_crc8(r_crc, r_data);
    end

    assign CRC = r_crc;
`else
    assign CRC = 8'h00;
`endif

    assign trecieve      = (r_state == S_ACK);
    assign fifo_we       = w_we;
    assign fifo_data_out = r_data;
    assign data          = r_data;
    assign error         = {1'b0, r_err};
    assign isFinish      = r_fin;
endmodule
